// File: rtl/controller.sv
// ---------------------------------------------------------------------------
// controller -- multicycle ARM-subset control unit
//
// Sequences each instruction through FETCH/DECODE and then a memory, data
// processing or branch path, driving the datapath selects and write strobes.
// Condition codes are evaluated once, at the end of DECODE, against the
// architectural Flags register; the result (CondExR) gates every write of
// the instruction.
//
// Ports
//   clk          in   1   sole clock, rising edge
//   reset        in   1   asynchronous, active-low
//   Instr        in   20  Instr[31:12]: Cond[31:28] Op[27:26] Funct[25:20] Rd[15:12]
//   ALUFlags     in   4   {N,Z,C,V} from the ALU in the current cycle
//   PCWrite      out  1   PC register enable
//   MemWrite     out  1   memory write strobe
//   RegWrite     out  1   register file write enable
//   IRWrite      out  1   instruction register enable
//   AdrSrc       out  1   0=PC, 1=Result
//   RegSrc       out  2   [0] read R15 on RA1, [1] read Rd on RA2
//   ALUSrcA      out  2   00=A, 01=PC
//   ALUSrcB      out  2   00=WriteData, 01=ExtImm, 10=4
//   ResultSrc    out  2   00=ALUOut, 01=Data, 10=ALUResult
//   ImmSrc       out  2   equals Op
//   ALUControl   out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
//   o_dbg_state  out  4   current FSM state encoding (debug observation)
//
// Configuration
//   CONTROLLER_CMP_EN  when defined, Funct[4:1]=1010 with S=1 executes as CMP
//                      (SUB, NZCV update, no register write). When undefined
//                      that encoding is treated as an unsupported opcode.
//
// Handshakes: none; all outputs are combinational decodes of the current
// state and the held instruction, valid for the whole cycle.
// ---------------------------------------------------------------------------
module controller (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:12]  Instr,
  input  logic [3:0]    ALUFlags,
  output logic          PCWrite,
  output logic          MemWrite,
  output logic          RegWrite,
  output logic          IRWrite,
  output logic          AdrSrc,
  output logic [1:0]    RegSrc,
  output logic [1:0]    ALUSrcA,
  output logic [1:0]    ALUSrcB,
  output logic [1:0]    ResultSrc,
  output logic [1:0]    ImmSrc,
  output logic [1:0]    ALUControl,
  output logic [3:0]    o_dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;    // {N,Z,C,V}
  logic        r_condex;

  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_rd;
  logic [3:0]  w_cmd;
  logic        w_unused_rn;

  assign w_cond      = Instr[31:28];
  assign w_op        = Instr[27:26];
  assign w_funct     = Instr[25:20];
  assign w_rd        = Instr[15:12];
  assign w_cmd       = w_funct[4:1];
  assign w_unused_rn = ^Instr[19:16];

  // ------------------------------------------------------------------------
  // Data-processing opcode decode
  // ------------------------------------------------------------------------
  logic [1:0] w_alu_op;
  logic       w_dp_ok;   // opcode is supported
  logic       w_is_cmp;  // compare: flags only, never a register write
  logic       w_dp_wr;

  always_comb begin
    w_alu_op = 2'b00;
    w_dp_ok  = 1'b1;
    w_is_cmp = 1'b0;
    case (w_cmd)
      4'b0100: w_alu_op = 2'b00;
      4'b0010: w_alu_op = 2'b01;
      4'b0000: w_alu_op = 2'b10;
      4'b1100: w_alu_op = 2'b11;
`ifdef CONTROLLER_CMP_EN
      4'b1010: begin
        if (w_funct[0]) begin
          w_alu_op = 2'b01;
          w_is_cmp = 1'b1;
        end else begin
          w_dp_ok = 1'b0;
        end
      end
`endif
      // Unsupported opcodes still run the ALU as ADD but commit nothing.
      default: w_dp_ok = 1'b0;
    endcase
  end

  assign w_dp_wr = w_dp_ok & ~w_is_cmp;

  // ------------------------------------------------------------------------
  // Condition evaluation against the architectural flags
  // ------------------------------------------------------------------------
  logic w_n, w_z, w_c, w_v;
  logic w_cond_ok;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'h0: w_cond_ok = w_z;
      4'h1: w_cond_ok = ~w_z;
      4'h2: w_cond_ok = w_c;
      4'h3: w_cond_ok = ~w_c;
      4'h4: w_cond_ok = w_n;
      4'h5: w_cond_ok = ~w_n;
      4'h6: w_cond_ok = w_v;
      4'h7: w_cond_ok = ~w_v;
      4'h8: w_cond_ok = w_c & ~w_z;
      4'h9: w_cond_ok = ~w_c | w_z;
      4'hA: w_cond_ok = (w_n == w_v);
      4'hB: w_cond_ok = (w_n != w_v);
      4'hC: w_cond_ok = ~w_z & (w_n == w_v);
      4'hD: w_cond_ok = w_z | (w_n != w_v);
      4'hE: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------------
  // State, condition latch and flags registers
  // ------------------------------------------------------------------------
  logic w_in_exec;
  logic w_flag_wr;

  assign w_in_exec = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
  assign w_flag_wr = w_in_exec & w_funct[0] & r_condex & w_dp_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_condex <= 1'b0;
      r_flags  <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_condex <= w_cond_ok;
      end
      if (w_flag_wr) begin
        r_flags[3:2] <= ALUFlags[3:2];
        // Logical ops leave C and V untouched.
        if (!w_alu_op[1]) begin
          r_flags[1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Next state and per-state controls
  // ------------------------------------------------------------------------
  logic w_next_pc;
  logic w_branch;
  logic w_regw;
  logic w_memw;
  logic w_irw;

  always_comb begin
    w_next     = r_state;
    w_next_pc  = 1'b0;
    w_branch   = 1'b0;
    w_regw     = 1'b0;
    w_memw     = 1'b0;
    w_irw      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irw     = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_next_pc = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (w_op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next  = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
        w_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUControl = w_alu_op;
        w_next     = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_op;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_regw = w_dp_wr;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are forced low combinationally while reset is held, since the
  // reset state (FETCH) would otherwise assert PCWrite and IRWrite.
  assign PCWrite  = reset & (w_next_pc | (w_branch & r_condex) |
                             (w_regw & r_condex & (w_rd == 4'hF)));
  assign MemWrite = reset & w_memw & r_condex;
  assign RegWrite = reset & w_regw & r_condex;
  assign IRWrite  = reset & w_irw;

  assign RegSrc      = {(w_op == 2'b01) & ~w_funct[0], (w_op == 2'b10)};
  assign ImmSrc      = w_op;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_controller.sv
// ---------------------------------------------------------------------------
// tb_controller -- directed, table-driven bench for controller.
// Each table record is one clock cycle: the instruction and ALU flags
// presented in that cycle plus the expected outputs and state.
// ---------------------------------------------------------------------------
module tb_controller;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [3:0]  o_dbg_state;

  always #5 clk = ~clk;

  controller dut (
    .clk         (clk),
    .reset       (reset),
    .Instr       (Instr),
    .ALUFlags    (ALUFlags),
    .PCWrite     (PCWrite),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .IRWrite     (IRWrite),
    .AdrSrc      (AdrSrc),
    .RegSrc      (RegSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ResultSrc   (ResultSrc),
    .ImmSrc      (ImmSrc),
    .ALUControl  (ALUControl),
    .o_dbg_state (o_dbg_state)
  );

`ifdef CONTROLLER_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECUTER = 4'd6;
  localparam logic [3:0] ST_EXECUTEI = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH   = 4'd9;

  // Instructions used below
  localparam logic [31:0] I_ADD    = 32'hE0821003;
  localparam logic [31:0] I_LDR    = 32'hE5921004;
  localparam logic [31:0] I_STR    = 32'hE5821004;
  localparam logic [31:0] I_SUBS   = 32'hE0500000;
  localparam logic [31:0] I_BEQ    = 32'h0A000002;
  localparam logic [31:0] I_ADDNE  = 32'h10821003;
  localparam logic [31:0] I_CMP    = 32'hE1500001;
  localparam logic [31:0] I_ORRI   = 32'hE3821003;
  localparam logic [31:0] I_AND    = 32'hE0021003;
  localparam logic [31:0] I_EOR    = 32'hE0221003;
  localparam logic [31:0] I_ADDPC  = 32'hE082F003;
  localparam logic [31:0] I_NOP    = 32'hEC000000;
  localparam logic [31:0] I_NEVER  = 32'hF0821003;
  localparam logic [31:0] I_ANDS   = 32'hE0100000;
  localparam logic [31:0] I_BHI    = 32'h8A000002;
  localparam logic [31:0] I_BCS    = 32'h2A000002;
  localparam logic [31:0] I_BVS    = 32'h6A000002;
  localparam logic [31:0] I_BMI    = 32'h4A000002;
  localparam logic [31:0] I_BAL    = 32'hEA000002;

  // ---------------- vector table ----------------
  // exp = {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,
  //        ALUSrcB,ResultSrc,ImmSrc,ALUControl}
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [3:0]  st;
    logic [16:0] exp;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [1:0] rs_of(input logic [31:0] i);
    return {(i[27:26] == 2'b01) && !i[20], i[27:26] == 2'b10};
  endfunction

  task automatic add(input logic [31:0] i, input logic [3:0] fl, input logic [3:0] st,
                     input logic pcw, input logic memw, input logic regw,
                     input logic irw, input logic adr, input logic [1:0] asa,
                     input logic [1:0] asb, input logic [1:0] rs,
                     input logic [1:0] aluc);
    vec_t v;
    v.instr = i;
    v.flags = fl;
    v.st    = st;
    v.exp   = {pcw, memw, regw, irw, adr, rs_of(i), asa, asb, rs, i[27:26], aluc};
    vq.push_back(v);
  endtask

  task automatic t_fetch(input logic [31:0] i);
    add(i, 4'h0, ST_FETCH, 1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00);
  endtask

  task automatic t_decode(input logic [31:0] i);
    add(i, 4'h0, ST_DECODE, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
  endtask

  task automatic t_memadr(input logic [31:0] i);
    add(i, 4'h0, ST_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
  endtask

  // Data processing: fl is driven in the execute cycle only.
  task automatic dp(input logic [31:0] i, input logic [3:0] fl, input logic [1:0] aluc,
                    input logic regw, input logic pcw);
    t_fetch(i);
    t_decode(i);
    if (i[25]) add(i, fl, ST_EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, aluc);
    else       add(i, fl, ST_EXECUTER, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, aluc);
    add(i, 4'h0, ST_ALUWB, pcw, 0, regw, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic ldr(input logic [31:0] i, input logic regw);
    t_fetch(i);
    t_decode(i);
    t_memadr(i);
    add(i, 4'h0, ST_MEMREAD, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(i, 4'h0, ST_MEMWB,   0, 0, regw, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
  endtask

  task automatic str(input logic [31:0] i, input logic memw);
    t_fetch(i);
    t_decode(i);
    t_memadr(i);
    add(i, 4'h0, ST_MEMWRITE, 0, memw, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic br(input logic [31:0] i, input logic taken);
    t_fetch(i);
    t_decode(i);
    add(i, 4'h0, ST_BRANCH, taken, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
            ALUSrcB, ResultSrc, ImmSrc, ALUControl};
  endfunction

  // Called at a falling edge; leaves the bench at the falling edge after
  // the last vector.
  task automatic run_range(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      Instr    = vq[k].instr[31:12];
      ALUFlags = vq[k].flags;
      #1;
      chk("outputs", k, {15'd0, outs()}, {15'd0, vq[k].exp});
      chk("state",   k, {28'd0, o_dbg_state}, {28'd0, vq[k].st});
      @(negedge clk);
    end
  endtask

  // ---------------- test ----------------
  int seg_a_end;

  initial begin
    reset    = 1'b0;
    Instr    = I_ADD[31:12];
    ALUFlags = 4'h0;

    // Segment A: main functions
    dp(I_ADD,   4'h0, 2'b00, 1, 0);
    ldr(I_LDR, 1);
    str(I_STR, 1);
    dp(I_SUBS,  4'b0100, 2'b01, 1, 0);          // Z=1
    br(I_BEQ, 1);
    dp(I_SUBS,  4'b0000, 2'b01, 1, 0);          // Z=0
    br(I_BEQ, 0);
    dp(I_SUBS,  4'b0100, 2'b01, 1, 0);          // Z=1
    dp(I_ADDNE, 4'h0, 2'b00, 0, 0);
    dp(I_CMP,   4'b0000, CMP_EN ? 2'b01 : 2'b00, 0, 0);
    br(I_BEQ, !CMP_EN);                          // CMP cleared Z only when enabled
    dp(I_ORRI,  4'h0, 2'b11, 1, 0);
    dp(I_AND,   4'h0, 2'b10, 1, 0);
    dp(I_EOR,   4'h0, 2'b00, 0, 0);              // unsupported
    dp(I_ADDPC, 4'h0, 2'b00, 1, 1);              // Rd=PC
    t_fetch(I_NOP);
    t_decode(I_NOP);
    dp(I_NEVER, 4'h0, 2'b00, 0, 0);
    dp(I_SUBS,  4'b0010, 2'b01, 1, 0);          // flags 0010
    dp(I_ANDS,  4'b0101, 2'b10, 1, 0);          // flags 0110 (C,V kept)
    br(I_BHI, 0);
    br(I_BCS, 1);
    br(I_BVS, 0);
    dp(I_SUBS,  4'b1111, 2'b01, 1, 0);          // flags 1111
    t_fetch(I_LDR);
    t_decode(I_LDR);
    t_memadr(I_LDR);
    seg_a_end = vq.size();

    // Segment B: after reset mid-LDR, flags must read 0000
    br(I_BEQ, 0);
    br(I_BCS, 0);
    br(I_BMI, 0);
    br(I_BVS, 0);
    br(I_BAL, 1);
    dp(I_ADD, 4'h0, 2'b00, 1, 0);

    // Reset held: strobes low even though state is FETCH
    #2;
    chk("rst_strobes", 0, {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'd0);
    chk("rst_state",   0, {28'd0, o_dbg_state}, {28'd0, ST_FETCH});
    @(posedge clk); #1;
    chk("rst_strobes", 1, {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_range(0, seg_a_end);

    // Now in MEMREAD of the LDR; assert reset mid-instruction
    Instr = I_LDR[31:12];
    #1;
    chk("memread_state",  0, {28'd0, o_dbg_state}, {28'd0, ST_MEMREAD});
    chk("memread_adrsrc", 0, {31'd0, AdrSrc}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_strobes", 0, {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'd0);
    chk("midrst_state",   0, {28'd0, o_dbg_state}, {28'd0, ST_FETCH});
    @(posedge clk); #1;
    chk("midrst_strobes", 1, {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'd0);
    chk("midrst_state",   1, {28'd0, o_dbg_state}, {28'd0, ST_FETCH});
    @(negedge clk);
    reset = 1'b1;

    run_range(seg_a_end, vq.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Instr  input  20  Instr[31:12] from instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
REQ-005 ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle.
REQ-006 PCWrite  output  1  PC register enable.
REQ-007 MemWrite  output  1  memory write strobe.
REQ-008 RegWrite  output  1  register file write enable.
REQ-009 IRWrite  output  1  instruction register enable.
REQ-010 AdrSrc  output  1  0=PC, 1=Result.
REQ-011 RegSrc  output  2  [0]=1 reads R15 on RA1 (branch); [1]=1 reads Rd on RA2 (store).
REQ-012 ALUSrcA  output  2  00=A, 01=PC.
REQ-013 ALUSrcB  output  2  00=WriteData, 01=ExtImm, 10=constant 4.
REQ-014 ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult.
REQ-015 ImmSrc  output  2  equals Op.
REQ-016 ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

Function
REQ-017 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH; fields not listed below are 0.
REQ-018 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALU ADD, NextPC=1; -> DECODE.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD; Op=01 -> MEMADR; Op=00,Funct[5]=0 -> EXECUTER; Op=00,Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (NOP).
REQ-020 MEMADR: ALUSrcB=01, ADD; Funct[0]=1 -> MEMREAD, else MEMWRITE. MEMREAD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegW=1 -> FETCH. MEMWRITE: AdrSrc=1, MemW=1 -> FETCH.
REQ-021 EXECUTER (ALUSrcB=00) / EXECUTEI (ALUSrcB=01): ALUControl from Funct[4:1] (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR) -> ALUWB. ALUWB: ResultSrc=00, RegW=1 -> FETCH.
REQ-022 Unsupported Funct[4:1] SHALL execute as ADD with RegW and flag write suppressed.
REQ-023 BRANCH: ALUSrcB=01, ResultSrc=10, ADD, Branch=1; -> FETCH.
REQ-024 CondExR register loaded at end of DECODE: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-025 RegWrite=RegW&CondExR; MemWrite=MemW&CondExR; PCWrite=NextPC | (Branch&CondExR) | (RegW&CondExR&Rd==1111).
REQ-026 Flags register SHALL load at end of EXECUTER/EXECUTEI when Funct[0]=1, CondExR=1, opcode supported: N,Z always; C,V only for ADD/SUB.
REQ-027 RegSrc[0]=1 whenever Op=10; RegSrc[1]=1 whenever Op=01 and Funct[0]=0; both independent of state.
REQ-028 Instruction latency: DP 4, LDR 5, STR 4, B 3 cycles; NOP 2.

Reset
REQ-029 reset low SHALL immediately set state FETCH, Flags 0000, CondExR 0, and force PCWrite, MemWrite, RegWrite, IRWrite to 0 while low.
REQ-030 First rising clk after reset release SHALL execute FETCH; reset mid-instruction abandons it with no writes.

Configuration
REQ-031 CONTROLLER_CMP_EN defined: Funct[4:1]=1010, Funct[0]=1 executes SUB, updates NZCV, RegWrite suppressed. Undefined: 1010 handled per REQ-022.

Verification
REQ-032 Reset, Instr=0xE0821003 (ADD) -> FETCH/DECODE/EXECUTER/ALUWB; PCWrite=1 cycle 1 only, RegWrite=1 cycle 4, ALUControl=00.
REQ-033 Instr=0xE5921004 (LDR) -> 5 cycles; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1.
REQ-034 Instr=0xE5821004 (STR) -> MemWrite=1 cycle 4 only, AdrSrc=1, RegSrc=10.
REQ-035 SUBS 0xE0500000 with ALUFlags=0100, then BEQ 0x0A000002 -> PCWrite=1 in BRANCH; with ALUFlags=0000 -> PCWrite=0 in BRANCH.
REQ-036 Flags Z=1, ADDNE 0x10821003 -> RegWrite=0 all cycles; CMP 0xE1500001 -> flags updated, RegWrite=0 with macro, flags unchanged without.
REQ-037 reset low during MEMREAD -> strobes 0 immediately; after release FETCH, Flags=0000.
